// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller for a 32-bit instruction word.
// Sequences instruction fetch, register-file strobes and ALU start/done handshakes.
module instr_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  input  logic [3:0]      flags_in,
  output logic [4:0]      rf_addr,
  output logic            rf_rd_en,
  output logic            rf_wr_en,
  output logic            rf_wr_sel,
  output logic [15:0]     imm_data,
  output logic [3:0]      alu_op,
  output logic            alu_start,
  input  logic            alu_done,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [15:0]     retired_q, retired_d;
  logic            exec_first_q, exec_first_d;

  logic [3:0] cond_mask_s;
  logic [3:0] opcode_s;
  logic [2:0] ctl_s;
  logic       cond_fail_s;
  logic       is_halt_s;
  logic       is_branch_s;

  assign cond_mask_s = ir_q[3:0];
  assign opcode_s    = ir_q[7:4];
  assign ctl_s       = ir_q[10:8];
  assign cond_fail_s = (cond_mask_s != 4'd0) && ((flags_in & cond_mask_s) == 4'd0);
  assign is_halt_s   = (opcode_s == 4'hF) && (ctl_s == 3'b000);
  assign is_branch_s = (opcode_s == 4'hE) && (ctl_s == 3'b000);

  // Next-state logic; DECODE resolves skip, halt, branch, execute in priority order.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    retired_d    = retired_q;
    exec_first_d = exec_first_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d      = START_PC;
          retired_d = 16'd0;
          state_d   = S_FETCH;
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (cond_fail_s) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end else if (is_halt_s) begin
          retired_d = retired_q + 16'd1;
          state_d   = S_HALT;
        end else if (is_branch_s) begin
          pc_d      = ir_q[16 +: PC_W];
          retired_d = retired_q + 16'd1;
          state_d   = S_FETCH;
        end else begin
          exec_first_d = 1'b1;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_first_d = 1'b0;
        if ((opcode_s == 4'h0) || alu_done) begin
          state_d = S_WB;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_WB: begin
        pc_d      = pc_q + PC_W'(1);
        retired_d = retired_q + 16'd1;
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      ir_q         <= 32'd0;
      retired_q    <= 16'd0;
      exec_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      retired_q    <= retired_d;
      exec_first_q <= exec_first_d;
    end
  end

  // Strobes are decoded from state and IR so each lasts exactly one state cycle.
  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign rf_rd_en  = (state_q == S_DECODE) && !cond_fail_s && !is_halt_s && !is_branch_s && ir_q[10];
  assign rf_wr_en  = (state_q == S_WB) && ir_q[9];
  assign rf_wr_sel = ir_q[8];
  assign alu_start = (state_q == S_EXEC) && exec_first_q && (opcode_s != 4'h0);
  assign rf_addr   = ir_q[15:11];
  assign imm_data  = ir_q[31:16];
  assign alu_op    = opcode_s;
  assign pc        = pc_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted    = (state_q == S_HALT);
  assign retired   = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: an instruction-level model expands each instruction into
// its expected per-cycle trace (inputs to drive plus outputs to expect) and one loop checks it.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, imem_ack, alu_done;
  logic [31:0] imem_data;
  logic [3:0]  flags_in;
  logic        imem_req, rf_rd_en, rf_wr_en, rf_wr_sel, alu_start, busy, halted;
  logic [7:0]  imem_addr, pc;
  logic [4:0]  rf_addr;
  logic [15:0] imm_data, retired;
  logic [3:0]  alu_op;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(8), .START_PC(8'd0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .flags_in(flags_in), .rf_addr(rf_addr), .rf_rd_en(rf_rd_en), .rf_wr_en(rf_wr_en),
    .rf_wr_sel(rf_wr_sel), .imm_data(imm_data), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .pc(pc), .busy(busy), .halted(halted), .retired(retired)
  );

  typedef struct {
    logic        rst, start, ack, done;
    logic [31:0] data;
    logic [3:0]  flags;
    logic        busy, halted, req, rd, wr, sel, alu;
    logic [7:0]  pc;
    logic [15:0] ret;
    logic        chk_ir;
    logic [31:0] ir;
    int          tag;
  } vec_t;

  vec_t        q[$];
  logic [7:0]  m_pc;
  logic [15:0] m_ret;
  logic        m_halt;
  int          tag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s tag=%0d cyc=%0d actual=%h required=%h", name, tag, cyc, act, exp);
  endtask

  function automatic vec_t base();
    vec_t v;
    v.rst = 1'b0; v.start = 1'b0; v.ack = 1'b0; v.done = 1'b0;
    v.data = 32'd0; v.flags = 4'd0;
    v.busy = 1'b1; v.halted = 1'b0; v.req = 1'b0; v.rd = 1'b0;
    v.wr = 1'b0; v.sel = 1'b0; v.alu = 1'b0;
    v.pc = m_pc; v.ret = m_ret; v.chk_ir = 1'b0; v.ir = 32'd0; v.tag = tag;
    return v;
  endfunction

  // Idle or halted cycles; optionally pulse start on the last one.
  task automatic gen_idle(input int n, input bit do_start, input bit stray);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = base();
      v.busy = 1'b0;
      v.halted = m_halt;
      if (stray) begin v.ack = 1'b1; v.done = 1'b1; v.data = 32'hFFFF_FFFF; end
      if (do_start && i == n - 1) v.start = 1'b1;
      q.push_back(v);
    end
    if (do_start) begin m_pc = 8'd0; m_ret = 16'd0; m_halt = 1'b0; end
  endtask

  // One instruction: fetch waits, decode, exec (latency lat), write-back.
  task automatic gen_instr(input logic [31:0] w, input int wait_c, input int lat,
                           input logic [3:0] fl, input bit stray, input int rst_at);
    vec_t v;
    bit skip, hlt, br;
    int n_exec;
    for (int i = 0; i < wait_c; i++) begin
      v = base(); v.req = 1'b1;
      if (stray) begin v.start = 1'b1; v.done = 1'b1; end
      q.push_back(v);
    end
    v = base(); v.req = 1'b1; v.ack = 1'b1; v.data = w;
    q.push_back(v);
    skip = (w[3:0] != 4'd0) && ((fl & w[3:0]) == 4'd0);
    hlt  = (w[7:4] == 4'hF) && (w[10:8] == 3'd0);
    br   = (w[7:4] == 4'hE) && (w[10:8] == 3'd0);
    v = base(); v.flags = fl; v.chk_ir = 1'b1; v.ir = w;
    v.rd = !skip && !hlt && !br && w[10];
    if (stray) begin v.ack = 1'b1; v.start = 1'b1; v.done = 1'b1; end
    q.push_back(v);
    if (skip) begin m_pc = m_pc + 8'd1; return; end
    if (hlt) begin m_ret = m_ret + 16'd1; m_halt = 1'b1; return; end
    if (br) begin m_pc = w[23:16]; m_ret = m_ret + 16'd1; return; end
    n_exec = (w[7:4] == 4'h0) ? 1 : lat + 1;
    for (int k = 0; k < n_exec; k++) begin
      v = base(); v.chk_ir = 1'b1; v.ir = w;
      v.alu  = (w[7:4] != 4'h0) && (k == 0);
      v.done = (w[7:4] != 4'h0) && (k == lat);
      if (stray) begin v.ack = 1'b1; v.start = 1'b1; end
      if (k == rst_at) begin
        v.rst = 1'b1;
        q.push_back(v);
        m_pc = 8'd0; m_ret = 16'd0; m_halt = 1'b0;
        v = base(); v.busy = 1'b0; v.rst = 1'b1;
        q.push_back(v);
        return;
      end
      q.push_back(v);
    end
    v = base(); v.chk_ir = 1'b1; v.ir = w; v.wr = w[9]; v.sel = w[8];
    if (stray) begin v.ack = 1'b1; v.start = 1'b1; v.done = 1'b1; end
    q.push_back(v);
    m_pc = m_pc + 8'd1;
    m_ret = m_ret + 16'd1;
  endtask

  // Compare each cycle's outputs to the trace, then drive that cycle's inputs.
  task automatic run_q();
    vec_t v;
    while (q.size() > 0) begin
      v = q.pop_front();
      check("ctrl", {busy, halted, imem_req, rf_rd_en, rf_wr_en, alu_start, pc, imem_addr, retired},
                    {v.busy, v.halted, v.req, v.rd, v.wr, v.alu, v.pc, v.pc, v.ret});
      if (v.chk_ir) check("ir_fields", {rf_addr, imm_data, alu_op}, {v.ir[15:11], v.ir[31:16], v.ir[7:4]});
      if (v.wr) check("wr_sel", {63'd0, rf_wr_sel}, {63'd0, v.sel});
      rst = v.rst; start = v.start; imem_ack = v.ack; imem_data = v.data;
      alu_done = v.done; flags_in = v.flags;
      @(posedge clk); #1; cyc++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; alu_done = 1'b0; imem_data = 32'd0; flags_in = 4'd0;
    m_pc = 8'd0; m_ret = 16'd0; m_halt = 1'b0; tag = 0;
    repeat (2) @(posedge clk);
    #1;

    tag = 1;
    gen_idle(2, 1'b0, 1'b1);
    gen_idle(1, 1'b1, 1'b0);
    gen_instr(32'h0000_1630, 0, 5, 4'd0, 1'b0, 2);
    gen_idle(1, 1'b1, 1'b0);
    run_q();
    check("t1_pc_after_restart", {56'd0, pc}, 64'd0);

    tag = 2;
    gen_instr(32'h00AB_0B00, 0, 0, 4'd0, 1'b0, -1);
    run_q();
    check("t2_pc", {56'd0, pc}, 64'd1);
    check("t2_retired", {48'd0, retired}, 64'd1);

    tag = 3;
    gen_instr(32'h1234_1630, 0, 3, 4'd0, 1'b0, -1);
    run_q();
    check("t3_retired", {48'd0, retired}, 64'd2);

    tag = 4;
    gen_instr(32'h0055_1B01, 0, 0, 4'b0000, 1'b0, -1);
    gen_instr(32'h0055_1B01, 0, 0, 4'b0001, 1'b0, -1);
    run_q();
    check("t4_pc", {56'd0, pc}, 64'd4);
    check("t4_retired", {48'd0, retired}, 64'd3);

    tag = 6;
    gen_instr(32'h0000_0000, 10, 0, 4'd0, 1'b1, -1);
    gen_instr(32'h0000_0450, 2, 0, 4'b1111, 1'b1, -1);
    run_q();
    check("t6_pc", {56'd0, pc}, 64'd6);

    tag = 5;
    gen_instr(32'h00FF_00E0, 0, 0, 4'd0, 1'b0, -1);
    gen_instr(32'h0000_0000, 0, 0, 4'd0, 1'b0, -1);
    gen_instr(32'h0000_00F0, 0, 0, 4'd0, 1'b0, -1);
    gen_idle(3, 1'b0, 1'b1);
    run_q();
    check("t5_pc_wrap", {56'd0, pc}, 64'd0);
    check("t5_halted", {62'd0, halted, busy}, 64'd2);
    check("t5_retired", {48'd0, retired}, 64'd8);
    gen_idle(1, 1'b1, 1'b0);
    gen_instr(32'h00AB_0B00, 0, 0, 4'd0, 1'b0, -1);
    run_q();
    check("t5_restart_retired", {48'd0, retired}, 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
